uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter among num_req byte sources using round-robin arbitration with packet lock.
- Once a source wins, it keeps the transmitter until it sends a byte flagged last, or until it stalls for longer than hold_timeout cycles.
- Sits between the byte producers (command responder, logger, debug port) and uart_tx; its output drives uart_tx tx_valid/tx_data/tx_ready directly.

Parameters:
num_req, 4, number of requesters (>=1)
hold_timeout, 1024, max idle cycles a locked requester may stall between bytes; 0 disables timeout
(derived) id_width = (num_req<=1) ? 1 : $clog2(num_req); tmo_width = $clog2(hold_timeout+2)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous reset, active-high
req_valid  input  num_req  per-requester byte valid
req_data  input  8*num_req  per-requester byte; requester i on bits [8i+7:8i]
req_last  input  num_req  byte is last of packet; sampled with req_data
req_ready  output  num_req  combinational; byte i accepted at the edge where req_valid[i]&&req_ready[i]
tx_valid  output  1  registered; to uart_tx tx_valid
tx_data  output  8  registered; to uart_tx tx_data
tx_ready  input  1  from uart_tx tx_ready
grant_valid  output  1  registered; a requester currently owns the transmitter
grant_id  output  id_width  registered; owning requester index, valid when grant_valid
timeout_err  output  1  registered one-cycle pulse on lock release by timeout

Behaviour:
- Reset: tx_valid=0, tx_data=0, grant_valid=0, grant_id=0, timeout_err=0, rr_ptr=0, timer=0, last_flag=0; state=ARB. All req_ready are 0 during rst.
- Output register empty means tx_valid==0. req_ready is asserted only when the register is empty and the state is not SEND; at most one bit is set at a time.
- State ARB (no owner):
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod num_req.
  - req_ready[winner]=1 in the same cycle.
  - On the accepting edge: tx_data<=byte, tx_valid<=1, last_flag<=req_last[winner], grant_id<=winner, grant_valid<=1, state<=SEND.
  - If no request, stay in ARB.
- State SEND:
  - Hold tx_valid/tx_data stable until tx_valid&&tx_ready at an edge, then tx_valid<=0 and timer<=0.
  - If last_flag: grant_valid<=0, rr_ptr<=(grant_id+1) mod num_req, state<=ARB.
  - Else: state<=HOLD.
- State HOLD (locked):
  - Only req_ready[grant_id] may be 1, and it is 1 in every HOLD cycle. Other requesters are ignored.
  - On accept: load byte, tx_valid<=1, last_flag<=req_last[grant_id], state<=SEND, timer<=0.
  - Else, if hold_timeout!=0: timer increments each cycle. When timer==hold_timeout-1 with no accept: timeout_err<=1 for one cycle, grant_valid<=0, rr_ptr<=grant_id+1 mod num_req, state<=ARB.
  - An accept in the same cycle as timer expiry wins: the byte is taken and there is no timeout.
- Latency: a byte accepted at edge k shows tx_valid=1 from cycle k+1. Back-to-back handoff of the register is not required; uart_tx frame time dominates.
- Ordering: bytes from one packet are never interleaved with another requester's bytes.
- rr_ptr wrap: index num_req-1 advances to 0.
- num_req==1: arbitration degenerates; grant_id is always 0; lock and timeout still apply.
- rst mid-packet: the byte in the register is dropped, the lock is released, and the next grant goes to the lowest index with valid set.
- Requester deasserting req_valid without a handshake is legal. The arbiter never captures data without req_ready.

Test Plan:
- Single packet: requester 2 sends 0x41,0x42,0x43(last) with the uart_tx model -> tx_data sequence 0x41,0x42,0x43; grant_id=2 throughout; grant_valid drops the cycle after the 3rd tx handshake.
- Contention: req 0 and 3 both valid after reset, single-byte packets -> order 0,3,0,3; rr_ptr=1 after first grant.
- Packet lock: req 1 sends 4-byte packet while req 0 holds valid continuously -> req_ready[0] stays 0 until req 1's last byte handshakes; then req 0 is granted.
- Timeout: hold_timeout=16; req 1 sends non-last byte then stalls -> timeout_err pulses exactly once, 16 cycles after tx handshake; next grant goes to req 2 if valid.
- Expiry collision: req 1 presents next byte in the exact expiry cycle -> byte accepted, no timeout_err.
- Reset mid-packet: assert rst during SEND -> next cycle tx_valid=0, grant_valid=0, req_ready all 0; after release, req 0 wins over req 3.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-source/transmitter bundle around uart_tx_arbiter.
// The master modport is the arbiter's view; slave is the producers plus uart_tx.
interface uart_tx_arbiter_if #(
  parameter int num_req = 4
);
  localparam int id_width = (num_req <= 1) ? 1 : $clog2(num_req);

  logic [num_req-1:0]   req_valid;
  logic [8*num_req-1:0] req_data;
  logic [num_req-1:0]   req_last;
  logic [num_req-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic                 grant_valid;
  logic [id_width-1:0]  grant_id;
  logic                 timeout_err;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant_valid, grant_id, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_valid, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among num_req byte sources; a winner
// keeps the transmitter until its last byte or until it stalls past hold_timeout.
module uart_tx_arbiter #(
  parameter int num_req      = 4,
  parameter int hold_timeout = 1024
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int id_width  = (num_req <= 1) ? 1 : $clog2(num_req);
  localparam int tmo_width = $clog2(hold_timeout + 2);
  localparam int tmo_last  = (hold_timeout == 0) ? 0 : hold_timeout - 1;

  typedef enum logic [1:0] {ARB, SEND, HOLD} state_e;

  state_e                state_q, state_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  last_flag_q, last_flag_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [id_width-1:0]   grant_id_q, grant_id_d;
  logic [id_width-1:0]   rr_ptr_q, rr_ptr_d;
  logic [tmo_width-1:0]  timer_q, timer_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  win_found;
  logic [id_width-1:0]   win_id;
  logic [id_width-1:0]   scan_id;
  int                    scan;
  logic [id_width-1:0]   sel_id;
  logic [num_req-1:0]    ready_vec;
  logic                  accept;
  logic [7:0]            sel_byte;

  function automatic logic [id_width-1:0] next_ptr(input logic [id_width-1:0] id);
    int n;
    n = int'(id) + 1;
    if (n >= num_req) n = 0;
    return id_width'(n);
  endfunction

  // Descending scan so the requester closest to rr_ptr overwrites the rest.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan      = 0;
    scan_id   = '0;
    for (int k = num_req - 1; k >= 0; k--) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= num_req) scan = scan - num_req;
      scan_id = id_width'(scan);
      if (bus.req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    last_flag_d   = last_flag_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    timeout_err_d = 1'b0;
    ready_vec     = '0;

    sel_id   = (state_q == HOLD) ? grant_id_q : win_id;
    sel_byte = bus.req_data[{sel_id, 3'b000} +: 8];

    if (!rst && !tx_valid_q) begin
      if (state_q == ARB && win_found) ready_vec[win_id] = 1'b1;
      else if (state_q == HOLD)        ready_vec[grant_id_q] = 1'b1;
    end
    accept = |(ready_vec & bus.req_valid);

    unique case (state_q)
      ARB: begin
        if (accept) begin
          tx_data_d     = sel_byte;
          tx_valid_d    = 1'b1;
          last_flag_d   = bus.req_last[sel_id];
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          timer_d    = '0;
          if (last_flag_q) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = next_ptr(grant_id_q);
            state_d       = ARB;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // A byte arriving in the expiry cycle beats the timeout.
        if (accept) begin
          tx_data_d   = sel_byte;
          tx_valid_d  = 1'b1;
          last_flag_d = bus.req_last[sel_id];
          timer_d     = '0;
          state_d     = SEND;
        end else if (hold_timeout != 0) begin
          if (timer_q == tmo_width'(tmo_last)) begin
            timeout_err_d = 1'b1;
            grant_valid_d = 1'b0;
            rr_ptr_d      = next_ptr(grant_id_q);
            state_d       = ARB;
          end else begin
            timer_d = timer_q + tmo_width'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      last_flag_q   <= 1'b0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      last_flag_q   <= last_flag_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.req_ready   = ready_vec;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus hand-built
// timeout, expiry-collision and mid-packet reset sequences.
module tb_uart_tx_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_tx_arbiter_if #(.num_req(4)) bus ();

  uart_tx_arbiter #(.num_req(4), .hold_timeout(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        t;
    logic [3:0]  e_rdy;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_gv;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic t, input logic [3:0] e_rdy,
                     input logic e_txv, input logic [7:0] e_txd, input logic e_gv,
                     input logic [1:0] e_gid);
    vec_t x;
    x.r = r; x.v = v; x.l = l; x.d = d; x.t = t;
    x.e_rdy = e_rdy; x.e_txv = e_txv; x.e_txd = e_txd; x.e_gv = e_gv; x.e_gid = e_gid;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic t);
    rst           = r;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.tx_ready  = t;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Packed view: {req_ready, tx_valid, tx_data, grant_valid, grant_id, timeout_err}
  task automatic expect_out(input string name, input logic [3:0] rdy, input logic txv,
                            input logic [7:0] txd, input logic gv, input logic [1:0] gid,
                            input logic to);
    logic [16:0] act;
    logic [16:0] exp;
    act = {bus.req_ready, bus.tx_valid, bus.tx_data, bus.grant_valid, bus.grant_id, bus.timeout_err};
    exp = {rdy, txv, txd, gv, gid, to};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b txv=%b txd=%h gv=%b gid=%0d to=%b, expected rdy=%b txv=%b txd=%h gv=%b gid=%0d to=%b",
               name, act[16:13], act[12], act[11:4], act[3], act[2:1], act[0],
               rdy, txv, txd, gv, gid, to);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b0);

    // Contention: req 0 and 3, single-byte packets -> 0,3,0,3
    add(1, 4'b1001, 4'b1111, 32'hA3A2A1A0, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    add(0, 4'b1001, 4'b1111, 32'hA3A2A1A0, 0, 4'b0001, 0, 8'h00, 0, 2'd0);
    add(0, 4'b1001, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 1, 8'hA0, 1, 2'd0);
    add(0, 4'b1001, 4'b1111, 32'hA3A2A1A0, 0, 4'b1000, 0, 8'hA0, 0, 2'd0);
    add(0, 4'b1001, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 1, 8'hA3, 1, 2'd3);
    add(0, 4'b1001, 4'b1111, 32'hA3A2A1A0, 0, 4'b0001, 0, 8'hA3, 0, 2'd3);
    add(0, 4'b1001, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 1, 8'hA0, 1, 2'd0);
    add(0, 4'b0000, 4'b0000, 32'hA3A2A1A0, 0, 4'b0000, 0, 8'hA0, 0, 2'd0);
    add(0, 4'b1001, 4'b1111, 32'hA3A2A1A0, 0, 4'b1000, 0, 8'hA0, 0, 2'd0);
    add(0, 4'b1001, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 1, 8'hA3, 1, 2'd3);
    add(0, 4'b0000, 4'b0000, 32'hA3A2A1A0, 0, 4'b0000, 0, 8'hA3, 0, 2'd3);
    // Single packet from req 2: 41, 42, 43(last)
    add(0, 4'b0100, 4'b0000, 32'h00410000, 0, 4'b0100, 0, 8'hA3, 0, 2'd3);
    add(0, 4'b0100, 4'b0000, 32'h00420000, 0, 4'b0000, 1, 8'h41, 1, 2'd2);
    add(0, 4'b0100, 4'b0000, 32'h00420000, 1, 4'b0000, 1, 8'h41, 1, 2'd2);
    add(0, 4'b0100, 4'b0000, 32'h00420000, 0, 4'b0100, 0, 8'h41, 1, 2'd2);
    add(0, 4'b0100, 4'b0100, 32'h00430000, 1, 4'b0000, 1, 8'h42, 1, 2'd2);
    add(0, 4'b0100, 4'b0100, 32'h00430000, 0, 4'b0100, 0, 8'h42, 1, 2'd2);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'h43, 1, 2'd2);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h43, 0, 2'd2);
    // Packet lock: req 1 sends B1..B4 while req 0 waits with C0
    add(0, 4'b0010, 4'b0000, 32'h0000B1C0, 0, 4'b0010, 0, 8'h43, 0, 2'd2);
    add(0, 4'b0011, 4'b0000, 32'h0000B2C0, 1, 4'b0000, 1, 8'hB1, 1, 2'd1);
    add(0, 4'b0011, 4'b0000, 32'h0000B2C0, 0, 4'b0010, 0, 8'hB1, 1, 2'd1);
    add(0, 4'b0011, 4'b0000, 32'h0000B3C0, 1, 4'b0000, 1, 8'hB2, 1, 2'd1);
    add(0, 4'b0011, 4'b0000, 32'h0000B3C0, 0, 4'b0010, 0, 8'hB2, 1, 2'd1);
    add(0, 4'b0011, 4'b0010, 32'h0000B4C0, 1, 4'b0000, 1, 8'hB3, 1, 2'd1);
    add(0, 4'b0011, 4'b0010, 32'h0000B4C0, 0, 4'b0010, 0, 8'hB3, 1, 2'd1);
    add(0, 4'b0001, 4'b0001, 32'h000000C0, 0, 4'b0000, 1, 8'hB4, 1, 2'd1);
    add(0, 4'b0001, 4'b0001, 32'h000000C0, 1, 4'b0000, 1, 8'hB4, 1, 2'd1);
    add(0, 4'b0001, 4'b0001, 32'h000000C0, 0, 4'b0001, 0, 8'hB4, 0, 2'd1);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'hC0, 1, 2'd0);
    add(0, 4'b0000, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'hC0, 0, 2'd0);

    @(negedge clk);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].t);
      #1;
      expect_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_txv, vecs[i].e_txd,
                 vecs[i].e_gv, vecs[i].e_gid, 1'b0);
      tick();
    end

    // Timeout: req 1 sends one non-last byte then stalls; req 2 waits
    drive(0, 4'b0010, 4'b0000, 32'h0000D100, 0);
    #1 expect_out("to_grant", 4'b0010, 0, 8'hC0, 0, 2'd0, 0);
    tick();
    drive(0, 4'b0100, 4'b0100, 32'h00E2D100, 1);
    #1 expect_out("to_send", 4'b0000, 1, 8'hD1, 1, 2'd1, 0);
    tick();
    bus.tx_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1 expect_out($sformatf("to_hold_c%0d", c), 4'b0010, 0, 8'hD1, 1, 2'd1, 0);
      tick();
    end
    #1 expect_out("to_pulse", 4'b0100, 0, 8'hD1, 0, 2'd1, 1);
    tick();
    bus.tx_ready = 1'b1;
    #1 expect_out("to_next_grant", 4'b0000, 1, 8'hE2, 1, 2'd2, 0);
    tick();
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    #1 expect_out("to_release", 4'b0000, 0, 8'hE2, 0, 2'd2, 0);

    // Expiry collision: req 1 offers its next byte exactly in the expiry cycle
    drive(0, 4'b0010, 4'b0000, 32'h0000D500, 0);
    #1 expect_out("col_grant", 4'b0010, 0, 8'hE2, 0, 2'd2, 0);
    tick();
    drive(0, 4'b0000, 4'b0000, 32'h0, 1);
    #1 expect_out("col_send", 4'b0000, 1, 8'hD5, 1, 2'd1, 0);
    tick();
    bus.tx_ready = 1'b0;
    repeat (15) tick();
    drive(0, 4'b0010, 4'b0010, 32'h0000D600, 0);
    #1 expect_out("col_expiry_cycle", 4'b0010, 0, 8'hD5, 1, 2'd1, 0);
    tick();
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    #1 expect_out("col_accept", 4'b0000, 1, 8'hD6, 1, 2'd1, 0);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    #1 expect_out("col_release", 4'b0000, 0, 8'hD6, 0, 2'd1, 0);

    // Reset while req 3's byte sits in the output register
    drive(0, 4'b1000, 4'b1000, 32'hF3000000, 0);
    #1 expect_out("rst_grant3", 4'b1000, 0, 8'hD6, 0, 2'd1, 0);
    tick();
    drive(1, 4'b1001, 4'b1001, 32'hF30000C0, 0);
    #1 expect_out("rst_asserted", 4'b0000, 1, 8'hF3, 1, 2'd3, 0);
    tick();
    #1 expect_out("rst_applied", 4'b0000, 0, 8'h00, 0, 2'd0, 0);
    tick();
    rst = 1'b0;
    #1 expect_out("post_rst_arb", 4'b0001, 0, 8'h00, 0, 2'd0, 0);
    tick();
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    #1 expect_out("post_rst_grant", 4'b0000, 1, 8'hC0, 1, 2'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
